// File: rtl/node_sweep_ctrl.sv
// rtl/node_sweep_ctrl.sv - per-node path-count sweep sequencer; SWEEP_SKIP_ZERO_EN skips zero-count non-last nodes
module node_sweep_ctrl #(
  parameter int PAYLOAD_WIDTH = 16,
  parameter int NODE_WIDTH    = 12,
  parameter int NUM_REQ       = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [NODE_WIDTH-1:0]            i_src_node,
  input  logic [NODE_WIDTH-1:0]            i_last_node,
  input  logic                             i_src_busy,
  input  logic [NUM_REQ-1:0]               i_req_vld,
  input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] i_req_paths,
  input  logic [NUM_REQ*NODE_WIDTH-1:0]    i_req_nodenum,
  output logic [NUM_REQ-1:0]               o_req_ack,
  output logic                             o_out_vld,
  output logic [NODE_WIDTH-1:0]            o_out_node,
  output logic [PAYLOAD_WIDTH-1:0]         o_out_paths,
  input  logic                             i_out_rdy,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [PAYLOAD_WIDTH-1:0]         o_result,
  output logic                             o_err,
  output logic                             o_sat
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NODE_WIDTH-1:0]    cur_q, cur_d, last_q, last_d;
  logic [PAYLOAD_WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic                     vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic                     err_q, err_d, sat_q, sat_d;

  logic [NUM_REQ-1:0]       match_vec, stale_vec, ack;
  logic [PAYLOAD_WIDTH-1:0] sel_paths;
  logic [PAYLOAD_WIDTH:0]   sum;
  logic                     found;

  always_comb begin
    match_vec = '0;
    stale_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      match_vec[i] = i_req_vld[i] && (i_req_nodenum[i*NODE_WIDTH +: NODE_WIDTH] == cur_q);
      stale_vec[i] = i_req_vld[i] && (i_req_nodenum[i*NODE_WIDTH +: NODE_WIDTH] <  cur_q);
    end
  end

  // Matches win over stale requests; within each class the lowest index goes first.
  always_comb begin
    ack       = '0;
    sel_paths = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && match_vec[i]) begin
        ack[i]    = 1'b1;
        sel_paths = i_req_paths[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        found     = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && stale_vec[j]) begin
        ack[j] = 1'b1;
        found  = 1'b1;
      end
    end
    if (state_q != COLLECT) ack = '0;
  end

  assign sum       = {1'b0, acc_q} + {1'b0, sel_paths};
  assign o_req_ack = ack;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    acc_d    = acc_q;
    result_d = result_q;
    vld_d    = vld_q;
    done_d   = done_q;
    err_d    = err_q;
    sat_d    = sat_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          cur_d    = i_src_node;
          last_d   = i_last_node;
          acc_d    = {{(PAYLOAD_WIDTH-1){1'b0}}, 1'b1};
          result_d = '0;
          sat_d    = 1'b0;
          if (i_last_node < i_src_node) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = COLLECT;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      COLLECT: begin
        if (|match_vec) begin
          acc_d = sum[PAYLOAD_WIDTH] ? '1 : sum[PAYLOAD_WIDTH-1:0];
          if (sum[PAYLOAD_WIDTH]) sat_d = 1'b1;
        end else if (|stale_vec) begin
          err_d = 1'b1;
        end else if (!i_src_busy) begin
`ifdef SWEEP_SKIP_ZERO_EN
          if (acc_q == '0 && cur_q != last_q) begin
            cur_d = cur_q + 1'b1;
          end else begin
            state_d = EMIT;
            vld_d   = 1'b1;
          end
`else
          state_d = EMIT;
          vld_d   = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (i_out_rdy) begin
          vld_d = 1'b0;
          if (cur_q == last_q) begin
            state_d  = DONE;
            result_d = acc_q;
            done_d   = 1'b1;
          end else begin
            state_d = COLLECT;
            cur_d   = cur_q + 1'b1;
            acc_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COLLECT) || (state_d == EMIT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
    end
  end

  assign o_out_vld   = vld_q;
  assign o_out_node  = cur_q;
  assign o_out_paths = acc_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_result    = result_q;
  assign o_err       = err_q;
  assign o_sat       = sat_q;

endmodule

// File: tb/tb_node_sweep_ctrl.sv
// tb/tb_node_sweep_ctrl.sv - directed self-checking bench for node_sweep_ctrl
module tb_node_sweep_ctrl;
  localparam int PW = 16;
  localparam int NW = 12;
  localparam int NR = 8;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_start = 1'b0;
  logic [NW-1:0]      i_src_node = '0;
  logic [NW-1:0]      i_last_node = '0;
  logic               i_src_busy = 1'b0;
  logic [NR-1:0]      i_req_vld = '0;
  logic [NR*PW-1:0]   i_req_paths;
  logic [NR*NW-1:0]   i_req_nodenum;
  logic [NR-1:0]      o_req_ack;
  logic               o_out_vld;
  logic [NW-1:0]      o_out_node;
  logic [PW-1:0]      o_out_paths;
  logic               i_out_rdy = 1'b1;
  logic               o_busy, o_done, o_err, o_sat;
  logic [PW-1:0]      o_result;

  logic [PW-1:0] req_p [NR];
  logic [NW-1:0] req_n [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign i_req_paths[g*PW +: PW]   = req_p[g];
    assign i_req_nodenum[g*NW +: NW] = req_n[g];
  end

  node_sweep_ctrl #(.PAYLOAD_WIDTH(PW), .NODE_WIDTH(NW), .NUM_REQ(NR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_src_node(i_src_node),
    .i_last_node(i_last_node), .i_src_busy(i_src_busy), .i_req_vld(i_req_vld),
    .i_req_paths(i_req_paths), .i_req_nodenum(i_req_nodenum), .o_req_ack(o_req_ack),
    .o_out_vld(o_out_vld), .o_out_node(o_out_node), .o_out_paths(o_out_paths),
    .i_out_rdy(i_out_rdy), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_err(o_err), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fails  = 0;
  int ack_q[$];
  int exp_ack[$];
  logic [31:0] rec_q[$];
  logic [31:0] exp_rec[$];
  logic multi_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int n, input int p);
    req_n[i] = n[NW-1:0];
    req_p[i] = p[PW-1:0];
    i_req_vld[i] = 1'b1;
  endtask

  // One clock: log acks and accepted records, then retire acked requests.
  task automatic tick();
    logic [NR-1:0] ack_s;
    #1;
    ack_s = o_req_ack;
    if ($countones(ack_s) > 1) multi_ack = 1'b1;
    for (int i = 0; i < NR; i++) if (ack_s[i]) ack_q.push_back(i);
    if (o_out_vld && i_out_rdy) rec_q.push_back({4'h0, o_out_node, o_out_paths});
    @(posedge i_clk);
    #1;
    i_req_vld = i_req_vld & ~ack_s;
  endtask

  task automatic start_sweep(input int src, input int last);
    ack_q.delete();
    rec_q.delete();
    exp_ack.delete();
    exp_rec.delete();
    i_src_node  = src[NW-1:0];
    i_last_node = last[NW-1:0];
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_until_done(input string tag);
    int n = 0;
    while (!o_done && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done"}, o_done, 1);
  endtask

  function automatic logic [31:0] rec(input int node, input int paths);
    logic [NW-1:0] nd = node[NW-1:0];
    logic [PW-1:0] pt = paths[PW-1:0];
    return {4'h0, nd, pt};
  endfunction

  task automatic compare_logs(input string tag);
    check({tag, "_rec_count"}, rec_q.size(), exp_rec.size());
    for (int i = 0; i < exp_rec.size() && i < rec_q.size(); i++)
      check({tag, "_rec"}, rec_q[i], exp_rec[i]);
    check({tag, "_ack_count"}, ack_q.size(), exp_ack.size());
    for (int i = 0; i < exp_ack.size() && i < ack_q.size(); i++)
      check({tag, "_ack"}, ack_q[i], exp_ack[i]);
  endtask

  initial begin
    logic stable, ack_seen;
    int wait_n;
    for (int i = 0; i < NR; i++) begin
      req_p[i] = '0;
      req_n[i] = '0;
    end
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_vld", o_out_vld, 0);
    check("rst_result", o_result, 0);
    check("rst_ack", o_req_ack, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Test 1: basic three-node sweep.
    set_req(0, 1, 3); set_req(5, 1, 4); set_req(2, 2, 2);
    start_sweep(0, 2);
    check("t1_busy", o_busy, 1);
    run_until_done("t1");
    exp_rec = '{rec(0, 1), rec(1, 7), rec(2, 2)};
    exp_ack = '{0, 5, 2};
    compare_logs("t1");
    check("t1_result", o_result, 2);
    check("t1_err", o_err, 0);
    check("t1_busy_end", o_busy, 0);
    tick();
    check("t1_vld_drop", o_out_vld, 0);

    // Test 2: two simultaneous matches, lowest index first.
    set_req(3, 1, 5); set_req(6, 1, 6);
    start_sweep(1, 1);
    run_until_done("t2");
    exp_rec = '{rec(1, 12)};
    exp_ack = '{3, 6};
    compare_logs("t2");
    check("t2_result", o_result, 12);

    // Test 3: backpressure in EMIT, start ignored while busy, stale after advance.
    i_out_rdy = 1'b0;
    start_sweep(3, 4);
    wait_n = 0;
    while (!o_out_vld && wait_n < 50) begin
      tick();
      wait_n++;
    end
    check("t3_vld", o_out_vld, 1);
    check("t3_node", o_out_node, 3);
    check("t3_paths", o_out_paths, 1);
    set_req(7, 3, 5);
    i_src_node = 9; i_last_node = 9; i_start = 1'b1;
    stable = 1'b1;
    ack_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (o_req_ack != '0) ack_seen = 1'b1;
      if (!o_out_vld || o_out_node != 3 || o_out_paths != 1) stable = 1'b0;
      tick();
      i_start = 1'b0;
    end
    check("t3_stable", stable, 1);
    check("t3_no_ack", ack_seen, 0);
    i_out_rdy = 1'b1;
    run_until_done("t3");
    exp_rec = '{rec(3, 1), rec(4, 0)};
    exp_ack = '{7};
    compare_logs("t3");
    check("t3_result", o_result, 0);
    check("t3_err", o_err, 1);

    // Test 4: saturation at all-ones.
    set_req(0, 0, 65533); set_req(1, 0, 3); set_req(2, 0, 7);
    start_sweep(0, 0);
    check("t4_err_clr", o_err, 0);
    run_until_done("t4");
    exp_rec = '{rec(0, 65535)};
    exp_ack = '{0, 1, 2};
    compare_logs("t4");
    check("t4_result", o_result, 65535);
    check("t4_sat", o_sat, 1);

    // Test 5: stale request dropped, match served first; then bad range.
    i_src_busy = 1'b1;
    start_sweep(4, 4);
    check("t5_sat_clr", o_sat, 0);
    set_req(1, 2, 9); set_req(3, 4, 2);
    tick();
    tick();
    tick();
    check("t5_err", o_err, 1);
    check("t5_busy_hold", o_busy, 1);
    i_src_busy = 1'b0;
    run_until_done("t5");
    exp_rec = '{rec(4, 3)};
    exp_ack = '{3, 1};
    compare_logs("t5");
    check("t5_result", o_result, 3);
    start_sweep(5, 3);
    check("t5b_done", o_done, 1);
    check("t5b_err", o_err, 1);
    check("t5b_result", o_result, 0);
    check("t5b_busy", o_busy, 0);

    // Test 6: async reset mid-COLLECT, then a restart.
    i_src_busy = 1'b1;
    start_sweep(0, 2);
    tick(); tick(); tick();
    check("t6_busy_pre", o_busy, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_done", o_done, 0);
    check("t6_rst_err", o_err, 0);
    check("t6_rst_vld", o_out_vld, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_src_busy = 1'b0;
    set_req(4, 2, 6);
    start_sweep(0, 3);
    run_until_done("t6");
`ifdef SWEEP_SKIP_ZERO_EN
    exp_rec = '{rec(0, 1), rec(2, 6), rec(3, 0)};
`else
    exp_rec = '{rec(0, 1), rec(1, 0), rec(2, 6), rec(3, 0)};
`endif
    exp_ack = '{4};
    compare_logs("t6");
    check("t6_result", o_result, 0);
    check("t6_err", o_err, 0);
    check("one_hot_ack", multi_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
